// File: rtl/sram_async_ctrl.sv
// Synchronous front-end for a 62256-class asynchronous SRAM.
// A single-cycle req/ready request becomes a timed SETUP/PULSE/HOLD cycle
// on the active-low CS/WE/OE pins. Stage lengths are set in clock cycles.
module sram_async_ctrl #(
    parameter int unsigned ADDR_WIDTH   = 15,
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned SETUP_CYCLES = 1,
    parameter int unsigned PULSE_CYCLES = 2,
    parameter int unsigned HOLD_CYCLES  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  ready,
    output logic                  ack,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  sram_ncs,
    output logic                  sram_nwe,
    output logic                  sram_noe,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    inout  wire  [DATA_WIDTH-1:0] sram_data
);

    // Counter only has to reach the longest stage length minus one
    localparam int unsigned MAX_SP  = (SETUP_CYCLES > PULSE_CYCLES) ? SETUP_CYCLES : PULSE_CYCLES;
    localparam int unsigned MAX_CYC = (MAX_SP > HOLD_CYCLES) ? MAX_SP : HOLD_CYCLES;
    localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    // A zero-length strobe would never move data
    if (PULSE_CYCLES < 1) begin : g_bad_pulse
        $error("sram_async_ctrl: PULSE_CYCLES must be >= 1");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        PULSE = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t                state;
    logic [CNT_W-1:0]      cnt;
    logic                  we_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  drive_en;

    // Idle decode is the only unregistered output
    assign ready = (state == IDLE);

    // Write data is driven only while a write cycle owns the bus
    assign sram_data = drive_en ? wdata_q : {DATA_WIDTH{1'bz}};

    // Access sequencer: state, stage timer and all registered pin/bus outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            we_q      <= 1'b0;
            wdata_q   <= '0;
            drive_en  <= 1'b0;
            ack       <= 1'b0;
            rdata     <= '0;
            sram_addr <= '0;
            sram_ncs  <= 1'b1;
            sram_nwe  <= 1'b1;
            sram_noe  <= 1'b1;
        end else begin
            ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        we_q      <= we;
                        wdata_q   <= wdata;
                        sram_addr <= addr;
                        sram_ncs  <= 1'b0;
                        // Reads enable OE from the start; writes drive the bus instead
                        sram_noe  <= we;
                        drive_en  <= we;
                        if (SETUP_CYCLES != 0) begin
                            state <= SETUP;
                            cnt   <= SETUP_LOAD;
                        end else begin
                            state    <= PULSE;
                            cnt      <= PULSE_LOAD;
                            sram_nwe <= ~we;
                        end
                    end
                end
                SETUP: begin
                    if (cnt == '0) begin
                        state    <= PULSE;
                        cnt      <= PULSE_LOAD;
                        sram_nwe <= ~we_q;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                PULSE: begin
                    if (cnt == '0) begin
                        if (!we_q) begin
                            rdata <= sram_data;
                        end
                        sram_ncs <= 1'b1;
                        sram_nwe <= 1'b1;
                        sram_noe <= 1'b1;
                        if (HOLD_CYCLES != 0) begin
                            state <= HOLD;
                            cnt   <= HOLD_LOAD;
                        end else begin
                            state    <= IDLE;
                            ack      <= 1'b1;
                            drive_en <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                HOLD: begin
                    if (cnt == '0) begin
                        state    <= IDLE;
                        ack      <= 1'b1;
                        drive_en <= 1'b0;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_async_ctrl.sv
// Bench for sram_async_ctrl: a default-timing instance (1/2/1) and a
// minimal-timing instance (0/1/0), each with a behavioural SRAM on its pins.
// Stimulus pushes expected completions; a monitor pops them on ack.
module tb_sram_async_ctrl;

    logic clk;
    logic rst;

    logic        req     [2];
    logic        we_i    [2];
    logic [14:0] addr_i  [2];
    logic [7:0]  wdata_i [2];
    logic        ready   [2];
    logic        ack     [2];
    logic [7:0]  rdata   [2];
    logic        ncs     [2];
    logic        nwe     [2];
    logic        noe     [2];
    logic [14:0] sram_addr [2];
    wire  [7:0]  bus_a;
    wire  [7:0]  bus_b;

    logic [7:0] mem_a [0:32767];
    logic [7:0] mem_b [0:32767];

    typedef struct {
        int          inst;
        logic        we;
        logic [14:0] addr;
        logic [7:0]  data;
        int          lat;
        int          ncs_n;
        int          nwe_n;
        int          noe_n;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   accepts [2];
    int   issued  [2];

    sram_async_ctrl #(.ADDR_WIDTH(15), .DATA_WIDTH(8),
                      .SETUP_CYCLES(1), .PULSE_CYCLES(2), .HOLD_CYCLES(1)) dut_a (
        .clk(clk), .rst(rst), .req(req[0]), .we(we_i[0]), .addr(addr_i[0]),
        .wdata(wdata_i[0]), .ready(ready[0]), .ack(ack[0]), .rdata(rdata[0]),
        .sram_ncs(ncs[0]), .sram_nwe(nwe[0]), .sram_noe(noe[0]),
        .sram_addr(sram_addr[0]), .sram_data(bus_a)
    );

    sram_async_ctrl #(.ADDR_WIDTH(15), .DATA_WIDTH(8),
                      .SETUP_CYCLES(0), .PULSE_CYCLES(1), .HOLD_CYCLES(0)) dut_b (
        .clk(clk), .rst(rst), .req(req[1]), .we(we_i[1]), .addr(addr_i[1]),
        .wdata(wdata_i[1]), .ready(ready[1]), .ack(ack[1]), .rdata(rdata[1]),
        .sram_ncs(ncs[1]), .sram_nwe(nwe[1]), .sram_noe(noe[1]),
        .sram_addr(sram_addr[1]), .sram_data(bus_b)
    );

    // Behavioural asynchronous SRAMs
    assign bus_a = (!ncs[0] && !noe[0]) ? mem_a[sram_addr[0]] : 8'bz;
    assign bus_b = (!ncs[1] && !noe[1]) ? mem_b[sram_addr[1]] : 8'bz;

    always @(posedge clk) begin
        if (!ncs[0] && !nwe[0]) mem_a[sram_addr[0]] <= bus_a;
        if (!ncs[1] && !nwe[1]) mem_b[sram_addr[1]] <= bus_b;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int s_of(input int g); return (g == 0) ? 1 : 0; endfunction
    function automatic int p_of(input int g); return (g == 0) ? 2 : 1; endfunction
    function automatic int h_of(input int g); return (g == 0) ? 1 : 0; endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Issue one request; hold keeps req high so a following call can chain back-to-back
    task automatic do_access(input int g, input logic w, input logic [14:0] a,
                             input logic [7:0] d, input logic hold, input logic in_ack_cycle);
        exp_t e;
        int   n;
        @(posedge clk); #1;
        req[g] = 1'b1; we_i[g] = w; addr_i[g] = a; wdata_i[g] = d;
        n = 0;
        @(negedge clk);
        while (!ready[g] && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!ready[g]) begin
            chk("accept_timeout", 32'(ready[g]), 32'd1);
            req[g] = 1'b0;
            return;
        end
        if (in_ack_cycle) chk("b2b_accept_in_ack_cycle", 32'(ack[g]), 32'd1);
        e.inst  = g;
        e.we    = w;
        e.addr  = a;
        e.data  = d;
        e.lat   = s_of(g) + p_of(g) + h_of(g);
        e.ncs_n = s_of(g) + p_of(g);
        e.nwe_n = w ? p_of(g) : 0;
        e.noe_n = w ? 0 : s_of(g) + p_of(g);
        sb.push_back(e);
        issued[g]++;
        @(posedge clk); #1;
        if (!hold) req[g] = 1'b0;
    endtask

    // Scoreboard monitor: times each access and checks it when ack appears
    task automatic monitor();
        int   cyc = 0;
        int   acc_cyc [2];
        int   ncs_n [2];
        int   nwe_n [2];
        int   noe_n [2];
        logic busy [2];
        exp_t e;
        for (int g = 0; g < 2; g++) begin
            busy[g] = 1'b0; acc_cyc[g] = 0; ncs_n[g] = 0; nwe_n[g] = 0; noe_n[g] = 0;
        end
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                sb.delete();
                for (int g = 0; g < 2; g++) busy[g] = 1'b0;
                continue;
            end
            for (int g = 0; g < 2; g++) begin
                if (busy[g]) begin
                    if (!ncs[g]) ncs_n[g]++;
                    if (!nwe[g]) nwe_n[g]++;
                    if (!noe[g]) noe_n[g]++;
                end
                if (ack[g]) begin
                    if (sb.size() == 0 || sb[0].inst != g) begin
                        chk($sformatf("unexpected_ack_dut%0d", g), 32'(ack[g]), 32'd0);
                    end else begin
                        e = sb.pop_front();
                        chk($sformatf("ack_latency_dut%0d", g), 32'(cyc - acc_cyc[g]), 32'(e.lat));
                        chk($sformatf("ncs_low_cycles_dut%0d", g), 32'(ncs_n[g]), 32'(e.ncs_n));
                        chk($sformatf("nwe_low_cycles_dut%0d", g), 32'(nwe_n[g]), 32'(e.nwe_n));
                        chk($sformatf("noe_low_cycles_dut%0d", g), 32'(noe_n[g]), 32'(e.noe_n));
                        if (e.we)
                            chk($sformatf("mem_written_dut%0d", g),
                                32'((g == 0) ? mem_a[e.addr] : mem_b[e.addr]), 32'(e.data));
                        else
                            chk($sformatf("rdata_dut%0d", g), 32'(rdata[g]), 32'(e.data));
                    end
                    busy[g] = 1'b0;
                end
                if (req[g] && ready[g]) begin
                    accepts[g]++;
                    acc_cyc[g] = cyc + 1;
                    ncs_n[g] = 0; nwe_n[g] = 0; noe_n[g] = 0;
                    busy[g] = 1'b1;
                end
            end
        end
    endtask

    initial begin
        logic [7:0] prev;
        rst = 1'b1;
        for (int g = 0; g < 2; g++) begin
            req[g] = 1'b0; we_i[g] = 1'b0; addr_i[g] = '0; wdata_i[g] = '0;
            accepts[g] = 0; issued[g] = 0;
        end
        fork
            monitor();
        join_none

        // Reset values on both instances
        #2;
        for (int g = 0; g < 2; g++) begin
            chk("rst_ready", 32'(ready[g]), 32'd1);
            chk("rst_ack", 32'(ack[g]), 32'd0);
            chk("rst_rdata", 32'(rdata[g]), 32'd0);
            chk("rst_sram_addr", 32'(sram_addr[g]), 32'd0);
            chk("rst_ncs", 32'(ncs[g]), 32'd1);
            chk("rst_nwe", 32'(nwe[g]), 32'd1);
            chk("rst_noe", 32'(noe[g]), 32'd1);
        end
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        // Test 1: write 0x42 @ 0x1234
        do_access(0, 1'b1, 15'h1234, 8'h42, 1'b0, 1'b0);
        repeat (6) @(posedge clk);
        #1;
        chk("idle_addr_retained", 32'(sram_addr[0]), 32'h1234);
        chk("idle_strobes_high", 32'({ncs[0], nwe[0], noe[0]}), 32'h7);

        // Test 2: read back 0x1234
        do_access(0, 1'b0, 15'h1234, 8'h42, 1'b0, 1'b0);
        repeat (6) @(posedge clk);

        // Test 3: write 0xA5 @ 0 with req held, then read it back-to-back
        do_access(0, 1'b1, 15'h0000, 8'hA5, 1'b1, 1'b0);
        do_access(0, 1'b0, 15'h0000, 8'hA5, 1'b0, 1'b1);
        repeat (6) @(posedge clk);

        // Test 4: reset during the write strobe aborts the access
        do_access(0, 1'b1, 15'h0055, 8'h77, 1'b0, 1'b0);
        @(posedge clk); #1;
        chk("t4_in_pulse_nwe", 32'(nwe[0]), 32'd0);
        #2 rst = 1'b1;
        #1;
        chk("t4_abort_strobes", 32'({ncs[0], nwe[0], noe[0]}), 32'h7);
        chk("t4_abort_ready", 32'(ready[0]), 32'd1);
        chk("t4_abort_ack", 32'(ack[0]), 32'd0);
        chk("t4_abort_rdata", 32'(rdata[0]), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (8) @(posedge clk);

        // Test 5: minimal-timing instance, write then read
        do_access(1, 1'b1, 15'h7FFF, 8'h5A, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        do_access(1, 1'b0, 15'h7FFF, 8'h5A, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        do_access(1, 1'b1, 15'h0001, 8'hC3, 1'b0, 1'b0);
        do_access(1, 1'b0, 15'h0001, 8'hC3, 1'b0, 1'b0);
        repeat (3) @(posedge clk);

        // Test 6: req pulsed while busy must be ignored
        prev = mem_a[15'h0200];
        do_access(0, 1'b1, 15'h0100, 8'h3C, 1'b0, 1'b0);
        @(posedge clk); #1;
        req[0] = 1'b1; we_i[0] = 1'b1; addr_i[0] = 15'h0200; wdata_i[0] = 8'h99;
        @(posedge clk); #1;
        req[0] = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("t6_busy_req_not_written", 32'(mem_a[15'h0200]), 32'(prev));

        // Every accepted request accounted for and every expectation consumed
        chk("accept_count_dut0", 32'(accepts[0]), 32'(issued[0]));
        chk("accept_count_dut1", 32'(accepts[1]), 32'(issued[1]));
        chk("pending_expectations", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
